// File: rtl/gerador_vai_vem_pkg.sv
// Shared FSM state encoding and width helper for the up/down pulse generator.
package gerador_vai_vem_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ESPERA    = 2'd1,
    REPETE    = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  // Smallest bit count able to hold 'valor' (at least 1).
  function automatic int unsigned largura(input int unsigned valor);
    int unsigned w;
    w = 1;
    while ((valor >> w) != 0) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
module debounce_botao
  import gerador_vai_vem_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 50000
) (
  input  logic clock,
  input  logic zera_s,
  input  logic entrada,
  output logic saida
);

  localparam int unsigned CW = largura(DEBOUNCE);

  logic [1:0]    sinc_q;
  logic          nivel_q, nivel_d;
  logic [CW-1:0] cont_q, cont_d;

  always_ff @(posedge clock) begin
    if (zera_s) begin
      sinc_q  <= 2'b00;
      nivel_q <= 1'b0;
      cont_q  <= '0;
    end else begin
      sinc_q  <= {sinc_q[0], entrada};
      nivel_q <= nivel_d;
      cont_q  <= cont_d;
    end
  end

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    nivel_d = nivel_q;
    cont_d  = '0;
    if (sinc_q[1] != nivel_q) begin
      if (cont_q == CW'(DEBOUNCE - 1)) begin
        nivel_d = sinc_q[1];
      end else begin
        cont_d = cont_q + CW'(1);
      end
    end
  end

  assign saida = nivel_q;

endmodule

// File: rtl/gerador_vai_vem.sv
// Two-button up/down request generator; auto-repeat enabled by GERADOR_AUTO_REPEAT_EN.
module gerador_vai_vem
  import gerador_vai_vem_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 50000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic       clock,
  input  logic       zera_s,
  input  logic       botao_vai,
  input  logic       botao_vem,
  output logic       vai,
  output logic       vem,
  output logic [1:0] db_estado
);

  if (DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_invalido
    $error("gerador_vai_vem: DEBOUNCE, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic nivel_vai, nivel_vem;

  debounce_botao #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb_vai (
    .clock  (clock),
    .zera_s (zera_s),
    .entrada(botao_vai),
    .saida  (nivel_vai)
  );

  debounce_botao #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb_vem (
    .clock  (clock),
    .zera_s (zera_s),
    .entrada(botao_vem),
    .saida  (nivel_vem)
  );

  estado_t estado_q, estado_d;
  logic    vai_q, vai_d;
  logic    vem_q, vem_d;
  logic    ativo_q, ativo_d;  // 1: vai owns the hold, 0: vem
  logic    pressionado, outro;

`ifdef GERADOR_AUTO_REPEAT_EN
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = largura(TMAX);

  logic [TW-1:0] timer_q, timer_d;
`endif

  always_ff @(posedge clock) begin
    if (zera_s) begin
      estado_q <= OCIOSO;
      vai_q    <= 1'b0;
      vem_q    <= 1'b0;
      ativo_q  <= 1'b0;
`ifdef GERADOR_AUTO_REPEAT_EN
      timer_q  <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      vai_q    <= vai_d;
      vem_q    <= vem_d;
      ativo_q  <= ativo_d;
`ifdef GERADOR_AUTO_REPEAT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign pressionado = ativo_q ? nivel_vai : nivel_vem;
  assign outro       = ativo_q ? nivel_vem : nivel_vai;

  always_comb begin
    estado_d = estado_q;
    vai_d    = 1'b0;
    vem_d    = 1'b0;
    ativo_d  = ativo_q;
`ifdef GERADOR_AUTO_REPEAT_EN
    timer_d  = timer_q;
`endif
    unique case (estado_q)
      OCIOSO: begin
        if (nivel_vai && nivel_vem) begin
          estado_d = BLOQUEADO;
        end else if (nivel_vai || nivel_vem) begin
          vai_d    = nivel_vai;
          vem_d    = nivel_vem;
          ativo_d  = nivel_vai;
          estado_d = ESPERA;
`ifdef GERADOR_AUTO_REPEAT_EN
          timer_d  = TW'(REPEAT_DELAY - 1);
`endif
        end
      end
`ifdef GERADOR_AUTO_REPEAT_EN
      ESPERA, REPETE: begin
        if (outro) begin
          estado_d = BLOQUEADO;
        end else if (!pressionado) begin
          estado_d = OCIOSO;
        end else if (timer_q == '0) begin
          vai_d    = ativo_q;
          vem_d    = !ativo_q;
          timer_d  = TW'(REPEAT_PERIOD - 1);
          estado_d = REPETE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`else
      ESPERA: begin
        if (outro) begin
          estado_d = BLOQUEADO;
        end else if (!pressionado) begin
          estado_d = OCIOSO;
        end
      end
`endif
      BLOQUEADO: begin
        if (!nivel_vai && !nivel_vem) begin
          estado_d = OCIOSO;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign vai       = vai_q;
  assign vem       = vem_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_gerador_vai_vem.sv
// Randomised scoreboard bench for gerador_vai_vem (either GERADOR_AUTO_REPEAT_EN build).
module tb_gerador_vai_vem;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clock = 1'b0;
  logic       zera_s;
  logic       botao_vai;
  logic       botao_vem;
  logic       vai;
  logic       vem;
  logic [1:0] db_estado;

  gerador_vai_vem #(
    .DEBOUNCE     (D),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clock    (clock),
    .zera_s   (zera_s),
    .botao_vai(botao_vai),
    .botao_vem(botao_vem),
    .vai      (vai),
    .vem      (vem),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Index of the most recent rising edge; inputs set after a falling edge land on edge_n+1.
  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  typedef struct {
    int borda;
    bit eh_vai;
  } pulso_t;

  pulso_t esperado[$];
  int     erros  = 0;
  int     checks = 0;

  task automatic check(input string nome, input int atual, input int requerido);
    checks++;
    if (atual !== requerido) begin
      erros++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nome, atual, requerido, edge_n);
    end
  endtask

  // Reference model: a clean press starting at raw edge k is accepted D+1 edges later and
  // pulses one edge after that; with auto-repeat, again after RD, then every RP, while the
  // button counts as held (last eligible pulse edge 'lim').
  task automatic push_trem(input bit eh_vai, input int k, input int lim);
    int p;
    pulso_t e;
    p = k + 2 + D;
    if (p > lim) return;
    e.borda  = p;
    e.eh_vai = eh_vai;
    esperado.push_back(e);
`ifdef GERADOR_AUTO_REPEAT_EN
    p += RD;
    while (p <= lim) begin
      e.borda = p;
      esperado.push_back(e);
      p += RP;
    end
`endif
  endtask

  task automatic dirige(input logic a, input logic b, input logic z, input int n);
    botao_vai = a;
    botao_vem = b;
    zera_s    = z;
    repeat (n) @(negedge clock);
  endtask

  task automatic aperta(input bit eh_vai, input int n);
    dirige(eh_vai, !eh_vai, 1'b0, n);
  endtask

  // Monitor: every presented pulse must match the head of the scoreboard.
  initial begin
    pulso_t e;
    forever begin
      @(negedge clock);
      if (vai === 1'b1 || vem === 1'b1) begin
        check("exclusivo", int'(vai && vem), 0);
        if (esperado.size() == 0) begin
          checks++;
          erros++;
          $display("FAIL inesperado: got pulse vai=%0b vem=%0b at edge %0d, expected none",
                   vai, vem, edge_n);
        end else begin
          e = esperado.pop_front();
          check("pulso_borda", edge_n, e.borda);
          check("pulso_tipo", int'(vai), int'(e.eh_vai));
        end
      end
    end
  end

  initial begin
    int tipo, k, h, h2, z, off, hb, extra, ng;
    bit b;

    botao_vai = 1'b0;
    botao_vem = 1'b0;
    zera_s    = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_estado", int'(db_estado), 0);
    check("reset_vai", int'(vai), 0);
    check("reset_vem", int'(vem), 0);
    dirige(1'b0, 1'b0, 1'b0, 6);

    for (int t = 0; t < 40; t++) begin
      tipo = (t < 5) ? t : int'($urandom_range(0, 4));
      b    = 1'($urandom_range(0, 1));
      case (tipo)
        0: begin
          ng = int'($urandom_range(0, 4));
          for (int g = 0; g < ng; g++) begin
            aperta(b, int'($urandom_range(1, D - 1)));
            dirige(1'b0, 1'b0, 1'b0, int'($urandom_range(1, 3)));
          end
          h = (t == 0) ? 200 : int'($urandom_range(1, 120));
          k = edge_n + 1;
          if (h >= D) push_trem(b, k, k + h + 1 + D);
          aperta(b, h);
          dirige(1'b0, 1'b0, 1'b0, D + 8);
        end
        1: begin
          h  = int'($urandom_range(D + 3, 45));
          k  = edge_n + 1;
          z  = k + h;
          push_trem(b, k, z - 1);
          aperta(b, h);
          dirige(b, !b, 1'b1, 1);
          check("zera_estado", int'(db_estado), 0);
          check("zera_saidas", int'(vai || vem), 0);
          h2 = int'($urandom_range(1, 50));
          k  = edge_n + 1;
          if (h2 >= D) push_trem(b, k, k + h2 + 1 + D);
          aperta(b, h2);
          dirige(1'b0, 1'b0, 1'b0, D + 8);
        end
        2: begin
          h = int'($urandom_range(D + 4, 100));
          dirige(1'b1, 1'b1, 1'b0, h);
          check("ambos_bloqueado", int'(db_estado), 3);
          dirige(1'b0, 1'b0, 1'b0, D + 8);
          check("ambos_liberado", int'(db_estado), 0);
        end
        3: begin
          off   = int'($urandom_range(D + 3, 40));
          hb    = int'($urandom_range(D + 3, 30));
          extra = int'($urandom_range(0, 20));
          k     = edge_n + 1;
          push_trem(b, k, k + off + 1 + D);
          aperta(b, off);
          dirige(1'b1, 1'b1, 1'b0, hb);
          check("segundo_bloqueado", int'(db_estado), 3);
          aperta(b, extra);
          dirige(1'b0, 1'b0, 1'b0, D + 8);
          check("segundo_liberado", int'(db_estado), 0);
        end
        default: begin
          for (int g = 0; g < 5; g++) begin
            aperta(b, 2);
            dirige(1'b0, 1'b0, 1'b0, 2);
          end
          dirige(1'b0, 1'b0, 1'b0, D + 8);
          check("quique_ocioso", int'(db_estado), 0);
        end
      endcase
    end

    dirige(1'b0, 1'b0, 1'b0, 30);
    check("fila_vazia", esperado.size(), 0);
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
